// File: rtl/arith_uart_rx.sv
// -----------------------------------------------------------------------------
// arith_uart_rx
//
// Serial receive front end for the 8-bit add/subtract datapath. Deserializes
// UART frames (8N1, or 8E1 when RX_PARITY_EN is defined) and pairs
// consecutive good bytes into a 16-bit operand word shaped like the switch bus.
//
// Compile-time option:
//   RX_PARITY_EN  defined   -> start + 8 data + even parity + stop (11 bits)
//                 undefined -> 8N1 (10 bits), parity_err held 0
//
// Ports:
//   clk         system clock, all state on the rising edge
//   rst_n       asynchronous active-low reset
//   rx_in       raw serial line, idle high
//   operands    [7:0] = first byte (A), [15:8] = second byte (B)
//   op_valid    one-cycle pulse when operands updates
//   rx_busy     high from the accepted start edge to the stop-bit sample
//   frame_err   one-cycle pulse on a bad stop bit
//   parity_err  one-cycle pulse on a parity mismatch
// -----------------------------------------------------------------------------
module arith_uart_rx #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 19_200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_in,
  output logic [15:0] operands,
  output logic        op_valid,
  output logic        rx_busy,
  output logic        frame_err,
  output logic        parity_err
);

  localparam int BAUD_DIV = CLK_FREQUENCY / BAUD_RATE;
  localparam int CNT_W    = $clog2(BAUD_DIV);
  // Terminal counts: half a bit to reach the start-bit centre, a full bit
  // between all later samples.
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t           state_reg;
  logic [1:0]       sync_reg;
  logic             rx_prev_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       bit_cnt_reg;
  logic [7:0]       shift_reg;
  logic [7:0]       a_hold_reg;
  logic             pair_second_reg;
  logic             rx_s;

`ifdef RX_PARITY_EN
  logic             par_bad_reg;
  logic             parity_err_reg;
  assign parity_err = parity_err_reg;
`else
  assign parity_err = 1'b0;
`endif

  assign rx_s = sync_reg[1];

  // Two-flop synchronizer plus a delayed copy for falling-edge detection.
  // All three idle high so reset exit never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg    <= 2'b11;
      rx_prev_reg <= 1'b1;
    end else begin
      sync_reg    <= {sync_reg[0], rx_in};
      rx_prev_reg <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      bit_cnt_reg     <= '0;
      shift_reg       <= '0;
      a_hold_reg      <= '0;
      pair_second_reg <= 1'b0;
      operands        <= '0;
      op_valid        <= 1'b0;
      rx_busy         <= 1'b0;
      frame_err       <= 1'b0;
`ifdef RX_PARITY_EN
      par_bad_reg     <= 1'b0;
      parity_err_reg  <= 1'b0;
`endif
    end else begin
      // Status strobes are single-cycle by default.
      op_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef RX_PARITY_EN
      parity_err_reg <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          // Only a true 1->0 transition starts a frame; a line that stays
          // low after a bad stop bit cannot retrigger.
          if (rx_prev_reg && !rx_s) begin
            state_reg <= START;
            cnt_reg   <= '0;
            rx_busy   <= 1'b1;
          end
        end

        START: begin
          if (cnt_reg == HALF_LAST) begin
            cnt_reg <= '0;
            if (!rx_s) begin
              state_reg   <= DATA;
              bit_cnt_reg <= '0;
            end else begin
              // Start bit vanished by its centre: treat as noise.
              state_reg <= IDLE;
              rx_busy   <= 1'b0;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        DATA: begin
          if (cnt_reg == FULL_LAST) begin
            cnt_reg   <= '0;
            shift_reg <= {rx_s, shift_reg[7:1]};  // LSB arrives first
            if (bit_cnt_reg == 3'd7) begin
`ifdef RX_PARITY_EN
              state_reg <= PARITY;
`else
              state_reg <= STOP;
`endif
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

`ifdef RX_PARITY_EN
        PARITY: begin
          if (cnt_reg == FULL_LAST) begin
            cnt_reg     <= '0;
            par_bad_reg <= (rx_s != ^shift_reg);  // even parity over data
            state_reg   <= STOP;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
`endif

        STOP: begin
          if (cnt_reg == FULL_LAST) begin
            cnt_reg   <= '0;
            state_reg <= IDLE;
            rx_busy   <= 1'b0;
            if (!rx_s) begin
              // Framing error wins over parity; either way the pairing restarts.
              frame_err       <= 1'b1;
              pair_second_reg <= 1'b0;
            end
`ifdef RX_PARITY_EN
            else if (par_bad_reg) begin
              parity_err_reg  <= 1'b1;
              pair_second_reg <= 1'b0;
            end
`endif
            else if (!pair_second_reg) begin
              a_hold_reg      <= shift_reg;
              pair_second_reg <= 1'b1;
            end else begin
              operands        <= {shift_reg, a_hold_reg};
              op_valid        <= 1'b1;
              pair_second_reg <= 1'b0;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        default: begin
          state_reg <= IDLE;
          rx_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arith_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_arith_uart_rx
//
// Bench for arith_uart_rx with BAUD_DIV = 16. Frames are bit-banged onto
// rx_in; a frame-level model (pair pointer, held A byte, expected words and
// error counts) predicts what the receiver should report, and a monitor logs
// what it actually reports.
// -----------------------------------------------------------------------------
module tb_arith_uart_rx;

  localparam int CLK_F = 16;
  localparam int BAUD  = 1;
  localparam int DIV   = CLK_F / BAUD;
`ifdef RX_PARITY_EN
  localparam int FBITS = 11;
`else
  localparam int FBITS = 10;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_in = 1'b1;
  logic [15:0] operands;
  logic        op_valid;
  logic        rx_busy;
  logic        frame_err;
  logic        parity_err;

  always #5 clk = ~clk;

  arith_uart_rx #(
    .CLK_FREQUENCY(CLK_F),
    .BAUD_RATE    (BAUD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_in     (rx_in),
    .operands  (operands),
    .op_valid  (op_valid),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .parity_err(parity_err)
  );

  int total = 0;
  int bad   = 0;
  int cycle = 0;

  // Observed activity
  logic [15:0] got_words[$];
  int          got_cycles[$];
  int          fe_cnt = 0;
  int          pe_cnt = 0;

  // Frame-level reference model
  logic [15:0] exp_words[$];
  int          exp_fe = 0;
  int          exp_pe = 0;
  bit          m_second = 1'b0;
  logic [7:0]  m_a = 8'h00;
  logic [15:0] m_ops = 16'h0000;

  always @(posedge clk) cycle++;

  always @(negedge clk) begin
    if (rst_n) begin
      if (op_valid) begin
        got_words.push_back(operands);
        got_cycles.push_back(cycle);
      end
      if (frame_err)  fe_cnt++;
      if (parity_err) pe_cnt++;
    end
  end

  task automatic clear_logs();
    got_words.delete();
    got_cycles.delete();
    exp_words.delete();
    fe_cnt = 0;
    pe_cnt = 0;
    exp_fe = 0;
    exp_pe = 0;
  endtask

  task automatic wait_bits(input int n);
    repeat (n * DIV) @(negedge clk);
  endtask

  task automatic model_reset();
    m_second = 1'b0;
    m_a      = 8'h00;
    m_ops    = 16'h0000;
  endtask

  // Drive one frame, optionally with a wrong parity bit and/or a low stop bit,
  // and advance the model by what the receiver should conclude.
  task automatic send_frame(input logic [7:0] b, input bit bad_par,
                            input bit bad_stop, input bit check_busy);
    bit par_hit;
    $display("frame data=%02h bad_par=%0d bad_stop=%0d", b, bad_par, bad_stop);
    rx_in = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      repeat (DIV) @(negedge clk);
      if (i == 3 && check_busy) begin
        total++;
        if (rx_busy !== 1'b1) begin
          bad++;
          $display("FAIL busy_mid_frame: got %b want 1", rx_busy);
        end
      end
    end
`ifdef RX_PARITY_EN
    rx_in = (^b) ^ bad_par;
    repeat (DIV) @(negedge clk);
    par_hit = bad_par;
`else
    par_hit = 1'b0;
`endif
    rx_in = ~bad_stop;
    repeat (DIV) @(negedge clk);
    if (bad_stop) begin
      rx_in = 1'b1;
      repeat (DIV) @(negedge clk);
      exp_fe++;
      m_second = 1'b0;
    end else if (par_hit) begin
      exp_pe++;
      m_second = 1'b0;
    end else if (!m_second) begin
      m_a      = b;
      m_second = 1'b1;
    end else begin
      m_ops    = {b, m_a};
      exp_words.push_back(m_ops);
      m_second = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    total += 5;
    if (operands !== 16'h0000) begin bad++; $display("FAIL reset_operands: got %h want 0000", operands); end
    if (op_valid !== 1'b0)     begin bad++; $display("FAIL reset_op_valid: got %b want 0", op_valid); end
    if (rx_busy !== 1'b0)      begin bad++; $display("FAIL reset_rx_busy: got %b want 0", rx_busy); end
    if (frame_err !== 1'b0)    begin bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    if (parity_err !== 1'b0)   begin bad++; $display("FAIL reset_parity_err: got %b want 0", parity_err); end
    rst_n = 1'b1;
    model_reset();
    wait_bits(1);
  endtask

  task automatic test_good_pair();
    clear_logs();
    send_frame(8'h25, 1'b0, 1'b0, 1'b1);
    wait_bits(1);
    total += 3;
    if (got_words.size() != 0) begin bad++; $display("FAIL pair_no_half_pulse: got %0d pulses want 0", got_words.size()); end
    if (operands !== 16'h0000) begin bad++; $display("FAIL pair_hold_after_first: got %h want 0000", operands); end
    if (rx_busy !== 1'b0)      begin bad++; $display("FAIL pair_busy_idle: got %b want 0", rx_busy); end
    send_frame(8'h13, 1'b0, 1'b0, 1'b1);
    wait_bits(1);
    total += 3;
    if (got_words.size() != 1) begin
      bad++; $display("FAIL pair_pulse_count: got %0d want 1", got_words.size());
    end else if (got_words[0] !== 16'h1325) begin
      bad++; $display("FAIL pair_word: got %h want 1325", got_words[0]);
    end
    if (operands !== 16'h1325) begin bad++; $display("FAIL pair_operands: got %h want 1325", operands); end
    if (fe_cnt + pe_cnt != 0)  begin bad++; $display("FAIL pair_no_errors: got %0d want 0", fe_cnt + pe_cnt); end
  endtask

  task automatic test_frame_error();
    clear_logs();
    send_frame(8'h25, 1'b0, 1'b1, 1'b0);
    wait_bits(1);
    total += 2;
    if (fe_cnt != 1)           begin bad++; $display("FAIL ferr_pulse: got %0d want 1", fe_cnt); end
    if (got_words.size() != 0) begin bad++; $display("FAIL ferr_no_word: got %0d want 0", got_words.size()); end
    send_frame(8'h01, 1'b0, 1'b0, 1'b0);
    send_frame(8'h02, 1'b0, 1'b0, 1'b0);
    wait_bits(1);
    total += 3;
    if (got_words.size() != 1 || got_words[0] !== 16'h0201) begin
      bad++; $display("FAIL ferr_recover_word: got %0d words first %h want 1 word 0201",
                      got_words.size(), (got_words.size() > 0) ? got_words[0] : 16'hxxxx);
    end
    if (operands !== 16'h0201) begin bad++; $display("FAIL ferr_operands: got %h want 0201", operands); end
    if (fe_cnt != exp_fe)      begin bad++; $display("FAIL ferr_total: got %0d want %0d", fe_cnt, exp_fe); end
  endtask

  task automatic test_glitch();
    clear_logs();
    rx_in = 1'b0;
    repeat (4) @(negedge clk);
    rx_in = 1'b1;
    wait_bits(2);
    total += 3;
    if (rx_busy !== 1'b0) begin bad++; $display("FAIL glitch_busy: got %b want 0", rx_busy); end
    if (got_words.size() + fe_cnt + pe_cnt != 0) begin
      bad++; $display("FAIL glitch_pulses: got %0d want 0", got_words.size() + fe_cnt + pe_cnt);
    end
    if (operands !== m_ops) begin bad++; $display("FAIL glitch_operands: got %h want %h", operands, m_ops); end
  endtask

  task automatic test_reset_mid_frame();
    clear_logs();
    // Leave the pair pointer on "second" so reset must also drop the held A.
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    rx_in = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx_in = 1'b1;  // 0x7F bits 0..2
      repeat (DIV) @(negedge clk);
    end
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total += 5;
    if (operands !== 16'h0000) begin bad++; $display("FAIL rstmid_operands: got %h want 0000", operands); end
    if (op_valid !== 1'b0)     begin bad++; $display("FAIL rstmid_op_valid: got %b want 0", op_valid); end
    if (rx_busy !== 1'b0)      begin bad++; $display("FAIL rstmid_rx_busy: got %b want 0", rx_busy); end
    if (frame_err !== 1'b0)    begin bad++; $display("FAIL rstmid_frame_err: got %b want 0", frame_err); end
    if (parity_err !== 1'b0)   begin bad++; $display("FAIL rstmid_parity_err: got %b want 0", parity_err); end
    rx_in = 1'b1;
    rst_n = 1'b1;
    model_reset();
    wait_bits(2);
    total++;
    if (got_words.size() + fe_cnt + pe_cnt != 0) begin
      bad++; $display("FAIL rstmid_exit_pulse: got %0d want 0", got_words.size() + fe_cnt + pe_cnt);
    end
    send_frame(8'h10, 1'b0, 1'b0, 1'b0);
    send_frame(8'h20, 1'b0, 1'b0, 1'b0);
    wait_bits(1);
    total += 2;
    if (got_words.size() != 1 || got_words[0] !== 16'h2010) begin
      bad++; $display("FAIL rstmid_word: got %0d words first %h want 1 word 2010",
                      got_words.size(), (got_words.size() > 0) ? got_words[0] : 16'hxxxx);
    end
    if (operands !== 16'h2010) begin bad++; $display("FAIL rstmid_operands_after: got %h want 2010", operands); end
  endtask

`ifdef RX_PARITY_EN
  task automatic test_parity();
    clear_logs();
    send_frame(8'h25, 1'b1, 1'b0, 1'b0);
    wait_bits(1);
    total += 2;
    if (pe_cnt != 1)           begin bad++; $display("FAIL par_pulse: got %0d want 1", pe_cnt); end
    if (got_words.size() != 0) begin bad++; $display("FAIL par_no_word: got %0d want 0", got_words.size()); end
    send_frame(8'h25, 1'b0, 1'b0, 1'b0);
    send_frame(8'h13, 1'b0, 1'b0, 1'b0);
    wait_bits(1);
    total += 2;
    if (got_words.size() != 1 || got_words[0] !== 16'h1325) begin
      bad++; $display("FAIL par_recover_word: got %0d words first %h want 1 word 1325",
                      got_words.size(), (got_words.size() > 0) ? got_words[0] : 16'hxxxx);
    end
    if (pe_cnt != 1) begin bad++; $display("FAIL par_total: got %0d want 1", pe_cnt); end
  endtask
`endif

  task automatic test_back_to_back();
    int t0;
    int lo;
    int hi;
    clear_logs();
    lo = (2 * FBITS - 1) * DIV;
    hi = 2 * FBITS * DIV + 4;
    t0 = cycle;
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0);
    send_frame(8'h80, 1'b0, 1'b0, 1'b0);
    wait_bits(1);
    total += 2;
    if (got_words.size() != 1 || got_words[0] !== 16'h80FF) begin
      bad++; $display("FAIL b2b_word: got %0d words first %h want 1 word 80ff",
                      got_words.size(), (got_words.size() > 0) ? got_words[0] : 16'hxxxx);
    end
    if (got_cycles.size() < 1 || got_cycles[0] - t0 < lo || got_cycles[0] - t0 > hi) begin
      bad++; $display("FAIL b2b_latency: got %0d cycles want %0d..%0d",
                      (got_cycles.size() > 0) ? got_cycles[0] - t0 : -1, lo, hi);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit bp;
    bit bs;
    clear_logs();
    for (int n = 0; n < 40; n++) begin
      b  = 8'($urandom);
      bs = ($urandom_range(0, 5) == 0);
      bp = ($urandom_range(0, 5) == 0);
      send_frame(b, bp, bs, 1'b0);
      wait_bits($urandom_range(0, 2));
    end
    wait_bits(1);
    total += 4;
    if (got_words.size() != exp_words.size()) begin
      bad++; $display("FAIL rand_word_count: got %0d want %0d", got_words.size(), exp_words.size());
    end else begin
      for (int i = 0; i < exp_words.size(); i++) begin
        total++;
        if (got_words[i] !== exp_words[i]) begin
          bad++; $display("FAIL rand_word[%0d]: got %h want %h", i, got_words[i], exp_words[i]);
        end
      end
    end
    if (fe_cnt != exp_fe)   begin bad++; $display("FAIL rand_frame_err: got %0d want %0d", fe_cnt, exp_fe); end
    if (pe_cnt != exp_pe)   begin bad++; $display("FAIL rand_parity_err: got %0d want %0d", pe_cnt, exp_pe); end
    if (operands !== m_ops) begin bad++; $display("FAIL rand_operands: got %h want %h", operands, m_ops); end
  endtask

  initial begin
    test_reset();
    test_good_pair();
    test_frame_error();
    test_glitch();
    test_reset_mid_frame();
`ifdef RX_PARITY_EN
    test_parity();
`endif
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
